// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_ctrl
// Description : SPI mode-0 master sequencer sitting behind a register bank.
//               On a start request it owns the bank's second port. For each
//               of n_tx_i words it reads the word, shifts it out MSB first on
//               MOSI while shifting MISO in, and writes the received word
//               back to the same address (full-duplex replace).
//
// Ports       : clk_i, rst_i          - clock, synchronous active-high reset
//               send_i, n_tx_i        - start request and word count
//               data_i                - registered bank read data
//               addr2_o, wr2_o,
//               data2_o, hold_ctrl_o  - bank port-2 address/write/priority
//               busy_o, done_o        - burst status
//               sclk_o, cs_o, mosi_o,
//               miso_i                - SPI pins (cs_o active low)
//
// Options     : SPI_CS_GAP_EN - when defined, cs_o is released between words
//               for CLK_DIV extra cycles (GAP state) before the next fetch.
//
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_ctrl #(
    parameter int N       = 32,
    parameter int W       = 8,
    parameter int CLK_DIV = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 send_i,
    input  logic [$clog2(N):0]   n_tx_i,
    input  logic [W-1:0]         data_i,
    output logic [$clog2(N)-1:0] addr2_o,
    output logic                 wr2_o,
    output logic [W-1:0]         data2_o,
    output logic                 hold_ctrl_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 sclk_o,
    output logic                 cs_o,
    output logic                 mosi_o,
    input  logic                 miso_i
);

    localparam int AW    = $clog2(N);
    localparam int CW    = AW + 1;
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(W) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
`ifdef SPI_CS_GAP_EN
    localparam logic [2:0] S_GAP   = 3'd6;
`endif

    logic [2:0]       r_state;
    logic [AW-1:0]    r_k;
    logic [CW-1:0]    r_cnt;
    logic [W-1:0]     r_tx;
    logic [W-1:0]     r_rx;
    logic [DIV_W-1:0] r_div;
    logic [BIT_W-1:0] r_bit;
    logic             r_sclk;
    logic             r_cs;
    logic             r_mosi;

    logic             w_last_word;
    logic             w_div_end;
    logic             w_last_bit;

    // Last word when k+1 is no longer below the latched count.
    assign w_last_word = (({1'b0, r_k} + CW'(1)) >= r_cnt);
    assign w_div_end   = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_last_bit  = (r_bit == BIT_W'(W - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_cnt   <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_div   <= '0;
            r_bit   <= '0;
            r_sclk  <= 1'b0;
            r_cs    <= 1'b1;
            r_mosi  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (send_i && (n_tx_i != '0)) begin
                        // Clamp to the bank depth so the word index never wraps.
                        r_cnt   <= (n_tx_i > CW'(N)) ? CW'(N) : n_tx_i;
                        r_k     <= '0;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // Bank registers the read of addr2_o; data_i is valid in LOAD.
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_tx    <= data_i;
                    r_mosi  <= data_i[W-1];
                    r_cs    <= 1'b0;
                    r_div   <= '0;
                    r_bit   <= '0;
                    r_sclk  <= 1'b0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (w_div_end) begin
                        r_div <= '0;
                        if (!r_sclk) begin
                            // Rising SCLK: capture MISO into the RX LSB.
                            r_sclk <= 1'b1;
                            r_rx   <= {r_rx[W-2:0], miso_i};
                        end else begin
                            // Falling SCLK: advance to the next TX bit, or finish.
                            r_sclk <= 1'b0;
                            if (w_last_bit) begin
                                r_state <= S_WRITE;
                            end else begin
                                r_bit  <= r_bit + BIT_W'(1);
                                r_tx   <= r_tx << 1;
                                r_mosi <= r_tx[W-2];
                            end
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                S_WRITE: begin
                    if (!w_last_word) begin
                        r_k <= r_k + AW'(1);
`ifdef SPI_CS_GAP_EN
                        // Release chip select between words; re-asserted in LOAD.
                        r_cs    <= 1'b1;
                        r_div   <= '0;
                        r_state <= S_GAP;
`else
                        r_state <= S_FETCH;
`endif
                    end else begin
                        r_state <= S_DONE;
                    end
                end
`ifdef SPI_CS_GAP_EN
                S_GAP: begin
                    if (w_div_end) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
`endif
                S_DONE: begin
                    r_cs    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Port 2 is owned in every state between start and DONE.
    assign hold_ctrl_o = (r_state != S_IDLE) && (r_state != S_DONE);
    assign busy_o      = hold_ctrl_o;
    assign done_o      = (r_state == S_DONE);
    assign wr2_o       = (r_state == S_WRITE);
    assign addr2_o     = r_k;
    assign data2_o     = r_rx;
    assign sclk_o      = r_sclk;
    assign cs_o        = r_cs;
    assign mosi_o      = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_ctrl
// Description : Self-checking bench for spi_master_ctrl with a register-bank
//               model on port 2 and a mode-0 SPI slave model on MISO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_ctrl;

    localparam int N       = 32;
    localparam int W       = 8;
    localparam int CLK_DIV = 2;
    localparam int AW      = $clog2(N);
    localparam int WORD_LAT = 2 * CLK_DIV * W + 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          send;
    logic [AW:0]   n_tx;
    logic [W-1:0]  data_rd;
    logic [AW-1:0] addr2;
    logic          wr2;
    logic [W-1:0]  data2;
    logic          hold;
    logic          busy;
    logic          done;
    logic          sclk;
    logic          cs;
    logic          mosi;
    logic          miso;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    spi_master_ctrl #(.N(N), .W(W), .CLK_DIV(CLK_DIV)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .send_i      (send),
        .n_tx_i      (n_tx),
        .data_i      (data_rd),
        .addr2_o     (addr2),
        .wr2_o       (wr2),
        .data2_o     (data2),
        .hold_ctrl_o (hold),
        .busy_o      (busy),
        .done_o      (done),
        .sclk_o      (sclk),
        .cs_o        (cs),
        .mosi_o      (mosi),
        .miso_i      (miso)
    );

    // ---------------- register bank model (port 2 + preload port) ----------
    logic [W-1:0]  mem [N];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [W-1:0]  pre_data;

    always @(posedge clk) begin
        if (pre_we)   mem[pre_addr] <= pre_data;
        else if (wr2) mem[addr2]    <= data2;
        data_rd <= mem[addr2];
    end

    // ---------------- SPI slave model (mode 0, MSB first) -------------------
    logic [W-1:0] slv_words [4];
    logic         loop_en;
    logic [W-1:0] slv_sh      = '0;
    logic         slv_miso    = 1'b0;
    logic         s_prev_cs   = 1'b1;
    logic         s_prev_sclk = 1'b0;
    int           slv_idx     = 0;
    int           slv_bits    = 0;

    always @(negedge clk) begin
        if (s_prev_cs && !cs) begin
            slv_idx  = 0;
            slv_bits = 0;
            slv_sh   = slv_words[0];
        end else if (s_prev_sclk && !sclk) begin
            slv_sh   = slv_sh << 1;
            slv_bits = slv_bits + 1;
            if (slv_bits == W) begin
                slv_bits = 0;
                if (slv_idx < 3) slv_idx = slv_idx + 1;
                slv_sh = slv_words[slv_idx];
            end
        end
        slv_miso    = slv_sh[W-1];
        s_prev_cs   = cs;
        s_prev_sclk = sclk;
    end

    assign miso = loop_en ? mosi : slv_miso;

    // ---------------- helpers ------------------------------------------------
    typedef struct {
        int                  n;
        logic [2:0][W-1:0]   bank;
        logic [2:0][W-1:0]   slv;
        logic [2:0][W-1:0]   expd;
        bit                  loopb;
        bit                  extra;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests = tests + 1;
        if (act !== expv) begin
            fails = fails + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic preload(input int a, input logic [W-1:0] d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = AW'(a);
        pre_data = d;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // Count cycles in which busy, done or a write appears while idle.
    task automatic idle_watch(input string name, input int ncyc);
        int ev = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (busy || done || wr2) ev = ev + 1;
        end
        check(name, ev, 0);
    endtask

    task automatic run_burst(input vec_t v);
        logic [AW-1:0] qa[$];
        logic [W-1:0]  qd[$];
        logic [AW-1:0] ea;
        logic [W-1:0]  ed;
        logic [W-1:0]  first_mosi = '0;
        logic          ps;
        logic          got_done = 1'b0;
        int            cyc = 0;
        int            rises = 0;
        int            hold_v = 0;
        int            cs_v = 0;
        int            exp_lat = WORD_LAT * v.n + 1;

        for (int i = 0; i < v.n; i++) begin
            preload(i, v.bank[i]);
            slv_words[i] = v.slv[i];
            qa.push_back(AW'(i));
            qd.push_back(v.expd[i]);
        end
        loop_en = v.loopb;
        @(negedge clk);
        send = 1'b1;
        n_tx = (AW+1)'(v.n);
        ps   = sclk;
        while (!got_done && cyc < exp_lat + 50) begin
            @(negedge clk);
            cyc = cyc + 1;
            if (cyc == 1) send = 1'b0;
            if (cyc == 5) n_tx = (AW+1)'(1);
            if (v.extra && cyc == 50) send = 1'b1;
            if (v.extra && cyc == 51) send = 1'b0;
            if (wr2) begin
                if (qa.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    ea = qa.pop_front();
                    ed = qd.pop_front();
                    check("write_addr_data", {addr2, data2}, {ea, ed});
                end
            end
            if (sclk && !ps) begin
                rises = rises + 1;
                if (rises <= W) first_mosi = {first_mosi[W-2:0], mosi};
            end
            ps = sclk;
            if (done) begin
                if (hold || busy) hold_v = hold_v + 1;
                got_done = 1'b1;
            end else if (!hold || !busy) begin
                hold_v = hold_v + 1;
            end
            if (cs == (cyc >= 3)) cs_v = cs_v + 1;
        end
        check("done_latency", cyc, exp_lat);
        check("hold_busy_continuous", hold_v, 0);
        check("cs_low_during_burst", cs_v, 0);
        check("sclk_rises", rises, v.n * W);
        check("mosi_first_word", first_mosi, v.bank[0]);
        check("writes_missing", qa.size(), 0);
        idle_watch("post_burst_activity", 40);
        for (int i = 0; i < v.n; i++) begin
            check("bank_readback", mem[i], v.expd[i]);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ps;
        int   falls;
        int   cyc;
        vec_t vr;

        rst      = 1'b1;
        send     = 1'b0;
        n_tx     = '0;
        pre_we   = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        loop_en  = 1'b0;
        for (int i = 0; i < 4; i++) slv_words[i] = '0;

        vecs[0] = '{n:1, bank:{8'h00, 8'h00, 8'hA5}, slv:{8'h00, 8'h00, 8'h00},
                    expd:{8'h00, 8'h00, 8'hA5}, loopb:1'b1, extra:1'b0};
        vecs[1] = '{n:1, bank:{8'h00, 8'h00, 8'hFF}, slv:{8'h00, 8'h00, 8'h3C},
                    expd:{8'h00, 8'h00, 8'h3C}, loopb:1'b0, extra:1'b0};
        vecs[2] = '{n:3, bank:{8'h33, 8'h22, 8'h11}, slv:{8'hE3, 8'hE2, 8'hE1},
                    expd:{8'hE3, 8'hE2, 8'hE1}, loopb:1'b0, extra:1'b1};
        vecs[3] = '{n:2, bank:{8'h00, 8'h7E, 8'h81}, slv:{8'h00, 8'h00, 8'h00},
                    expd:{8'h00, 8'h7E, 8'h81}, loopb:1'b1, extra:1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cs", cs, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_wr2", wr2, 0);
        check("rst_hold", hold, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr2", addr2, 0);
        check("rst_data2", data2, 0);
        rst = 1'b0;

        for (int t = 0; t < 4; t++) begin
            run_burst(vecs[t]);
        end

        // Zero-length start is ignored
        @(negedge clk);
        n_tx = '0;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        idle_watch("zero_count_ignored", 40);

        // Reset in the middle of SHIFT, after three bits of word 0
        preload(0, 8'h5A);
        slv_words[0] = 8'hC3;
        loop_en = 1'b0;
        @(negedge clk);
        n_tx  = (AW+1)'(1);
        send  = 1'b1;
        ps    = sclk;
        falls = 0;
        cyc   = 0;
        while (falls < 3 && cyc < 200) begin
            @(negedge clk);
            cyc = cyc + 1;
            send = 1'b0;
            if (ps && !sclk) falls = falls + 1;
            ps = sclk;
        end
        check("mid_shift_reached", falls, 3);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cs", cs, 1);
        check("midrst_sclk", sclk, 0);
        check("midrst_hold", hold, 0);
        check("midrst_busy", busy, 0);
        check("midrst_wr2", wr2, 0);
        rst = 1'b0;
        idle_watch("midrst_no_activity", 80);
        check("midrst_bank_untouched", mem[0], 8'h5A);

        // Fresh burst after the aborted one
        vr = '{n:1, bank:{8'h00, 8'h00, 8'h5A}, slv:{8'h00, 8'h00, 8'hC3},
               expd:{8'h00, 8'h00, 8'hC3}, loopb:1'b0, extra:1'b0};
        run_burst(vr);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
